// File: rtl/router_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : router_ctrl_if
//  Brief    : Packet-side and FIFO-side signal bundle for router_ctrl.
//             The master modport is the sender/FIFO environment and the
//             slave modport is the router controller itself.
//  Revision : 1.0  initial release
// ============================================================================
interface router_ctrl_if;
  // Sender and FIFO status toward the controller
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  // Controller results toward the FIFOs and sender
  logic [2:0] write_enb;
  logic [7:0] fifo_data;
  logic       lfd_state;
  logic       busy;
  logic       err;
  logic [2:0] vld_out;
  logic [2:0] soft_reset;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
    input  write_enb, fifo_data, lfd_state, busy, err, vld_out, soft_reset
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
    output write_enb, fifo_data, lfd_state, busy, err, vld_out, soft_reset
  );
endinterface
`default_nettype wire

// File: rtl/router_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : router_ctrl
//  Brief    : Three-channel packet router controller. Decodes the header
//             byte, steers header/payload/parity bytes into one of three
//             FIFOs, stalls the sender on full FIFOs, checks parity and
//             flushes channels whose data sits unread for TIMEOUT cycles.
//  Revision : 1.0  initial release
// ============================================================================
module router_ctrl #(
  parameter int TIMEOUT = 30
) (
  input  logic         clock,
  input  logic         resetn,
  router_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    WAIT_TILL_EMPTY    = 3'd1,
    LOAD_FIRST_DATA    = 3'd2,
    LOAD_DATA          = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    LOAD_PARITY        = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  // Counter value at which the next unread cycle triggers a flush
  localparam logic [4:0] C_CNT_LAST = 5'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_addr;
  logic [7:0] r_header;
  logic [7:0] r_parity;
  logic [7:0] r_rx_parity;
  logic       r_err;
  logic [2:0] w_soft_reset;
  logic [2:0] w_wr_onehot;

  logic w_write;
  logic w_busy;
  logic w_lfd;
  logic w_latch_hdr;
  logic w_load_first;
  logic w_par_xor;
  logic w_latch_rx;
  logic w_check;
  logic w_abort;
  logic w_hdr_ok;

  // Pick one channel bit by a 2-bit address; address 3 maps to 0
  function automatic logic sel3(input logic [2:0] v, input logic [1:0] i);
    logic r;
    case (i)
      2'd0:    r = v[0];
      2'd1:    r = v[1];
      2'd2:    r = v[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign w_hdr_ok = bus.pkt_valid && (bus.data_in[1:0] != 2'd3);
  // A flush of the channel being loaded cancels the packet from any busy state
  assign w_abort  = (r_state != DECODE_ADDRESS) && sel3(w_soft_reset, r_addr);

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= DECODE_ADDRESS;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus per-state strobes for the datapath and outputs
  always_comb begin
    w_next_state = r_state;
    w_write      = 1'b0;
    w_busy       = 1'b0;
    w_lfd        = 1'b0;
    w_latch_hdr  = 1'b0;
    w_load_first = 1'b0;
    w_par_xor    = 1'b0;
    w_latch_rx   = 1'b0;
    w_check      = 1'b0;
    case (r_state)
      DECODE_ADDRESS: begin
        if (w_hdr_ok) begin
          w_latch_hdr  = 1'b1;
          w_next_state = sel3(bus.fifo_empty, bus.data_in[1:0]) ?
                         LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        w_busy = 1'b1;
        if (sel3(bus.fifo_empty, r_addr)) w_next_state = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: begin
        w_busy       = 1'b1;
        w_lfd        = 1'b1;
        w_write      = 1'b1;
        w_load_first = 1'b1;
        w_next_state = LOAD_DATA;
      end
      LOAD_DATA: begin
        if (!bus.pkt_valid) begin
          w_busy       = 1'b1;
          w_next_state = LOAD_PARITY;
        end else if (sel3(bus.fifo_full, r_addr)) begin
          w_busy       = 1'b1;
          w_next_state = FIFO_FULL_STATE;
        end else begin
          w_write   = 1'b1;
          w_par_xor = 1'b1;
        end
      end
      FIFO_FULL_STATE: begin
        w_busy = 1'b1;
        if (!sel3(bus.fifo_full, r_addr)) w_next_state = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        // The sender held the stalled byte; write it now
        w_busy       = 1'b1;
        w_write      = 1'b1;
        w_par_xor    = 1'b1;
        w_next_state = bus.pkt_valid ? LOAD_DATA : LOAD_PARITY;
      end
      LOAD_PARITY: begin
        w_busy = 1'b1;
        if (!sel3(bus.fifo_full, r_addr)) begin
          w_write      = 1'b1;
          w_latch_rx   = 1'b1;
          w_next_state = CHECK_PARITY_ERROR;
        end
      end
      CHECK_PARITY_ERROR: begin
        w_busy       = 1'b1;
        w_check      = 1'b1;
        w_next_state = DECODE_ADDRESS;
      end
      default: w_next_state = DECODE_ADDRESS;
    endcase
    if (w_abort) begin
      w_next_state = DECODE_ADDRESS;
      w_write      = 1'b0;
      w_lfd        = 1'b0;
      w_load_first = 1'b0;
      w_par_xor    = 1'b0;
      w_latch_rx   = 1'b0;
      w_check      = 1'b0;
    end
  end

  // Header, running parity, received parity and error flag
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_addr      <= 2'd0;
      r_header    <= 8'h00;
      r_parity    <= 8'h00;
      r_rx_parity <= 8'h00;
      r_err       <= 1'b0;
    end else begin
      if (w_latch_hdr) begin
        r_addr   <= bus.data_in[1:0];
        r_header <= bus.data_in;
      end
      if (w_load_first) begin
        r_parity <= r_header;
        r_err    <= 1'b0;
      end
      if (w_par_xor)  r_parity    <= r_parity ^ bus.data_in;
      if (w_latch_rx) r_rx_parity <= bus.data_in;
      if (w_check)    r_err       <= (r_parity != r_rx_parity);
    end
  end

  // One-hot write strobe for the latched destination
  always_comb begin
    w_wr_onehot = 3'b000;
    case (r_addr)
      2'd0:    w_wr_onehot = 3'b001;
      2'd1:    w_wr_onehot = 3'b010;
      2'd2:    w_wr_onehot = 3'b100;
      default: w_wr_onehot = 3'b000;
    endcase
  end

  // Per-channel unread-data watchdog
  for (genvar k = 0; k < 3; k++) begin : g_chan
    logic [4:0] r_cnt;
    logic       r_sr;

    // A read or an empty FIFO restarts the count; expiry flushes for one cycle
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        r_cnt <= 5'd0;
        r_sr  <= 1'b0;
      end else if (bus.read_enb[k] || bus.fifo_empty[k]) begin
        r_cnt <= 5'd0;
        r_sr  <= 1'b0;
      end else if (r_cnt == C_CNT_LAST) begin
        r_cnt <= 5'd0;
        r_sr  <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 5'd1;
        r_sr  <= 1'b0;
      end
    end

    assign w_soft_reset[k] = r_sr;
  end

  assign bus.write_enb  = w_write ? w_wr_onehot : 3'b000;
  assign bus.fifo_data  = (r_state == LOAD_FIRST_DATA) ? r_header : bus.data_in;
  assign bus.lfd_state  = w_lfd;
  assign bus.busy       = w_busy;
  assign bus.err        = r_err;
  assign bus.vld_out    = ~bus.fifo_empty;
  assign bus.soft_reset = w_soft_reset;

endmodule
`default_nettype wire

// File: tb/tb_router_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_router_ctrl
//  Brief    : Directed bench for router_ctrl: a per-cycle vector table for
//             whole packets plus hand sequences for watchdog, abort and
//             asynchronous reset behaviour.
//  Revision : 1.0  initial release
// ============================================================================
module tb_router_ctrl;

  localparam int C_TIMEOUT = 8;

  logic clock = 1'b0;
  logic resetn;

  router_ctrl_if bus ();

  router_ctrl #(.TIMEOUT(C_TIMEOUT)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       pv;
    logic [7:0] din;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] we;
    logic [7:0] fd;
    logic       lfd;
    logic       busy;
    logic       err;
    logic [2:0] vld;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic pv, input logic [7:0] din, input logic [2:0] full,
                     input logic [2:0] empty, input logic [2:0] we, input logic [7:0] fd,
                     input logic lfd, input logic busy, input logic err, input logic [2:0] vld);
    vec_t v;
    v.pv = pv; v.din = din; v.full = full; v.empty = empty; v.we = we;
    v.fd = fd; v.lfd = lfd; v.busy = busy; v.err = err; v.vld = vld;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input bit ok, input string info);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: %s", name, info);
    end
  endtask

  // Counts soft_reset[ch] high cycles over max_cyc edges; first is the edge index
  task automatic watch_pulse(input int max_cyc, input int ch, output int first, output int cnt);
    first = -1;
    cnt   = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clock); #2;
      if (bus.soft_reset[ch]) begin
        if (first < 0) first = c;
        cnt++;
      end
    end
  endtask

  task automatic step();
    @(negedge clock); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int  f, n;
    bit  seen0, seen2, ok;

    resetn         = 1'b0;
    bus.pkt_valid  = 1'b0;
    bus.data_in    = 8'h00;
    bus.fifo_full  = 3'b000;
    bus.fifo_empty = 3'b111;
    bus.read_enb   = 3'b000;

    #3;
    check("reset_state",
          bus.write_enb === 3'b000 && bus.busy === 1'b0 && bus.lfd_state === 1'b0 &&
          bus.err === 1'b0 && bus.soft_reset === 3'b000 && bus.vld_out === 3'b000,
          $sformatf("got we=%b busy=%b lfd=%b err=%b sr=%b vld=%b, want all zero",
                    bus.write_enb, bus.busy, bus.lfd_state, bus.err, bus.soft_reset, bus.vld_out));
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;

    //   pv  din    full    empty   we      fd     lfd busy err vld
    // Good packet to channel 1: parity 0D^AA^55^0F = FD
    add(1, 8'h0D, 3'b000, 3'b111, 3'b000, 8'h00, 0, 0, 0, 3'b000);
    add(1, 8'hAA, 3'b000, 3'b111, 3'b010, 8'h0D, 1, 1, 0, 3'b000);
    add(1, 8'hAA, 3'b000, 3'b111, 3'b010, 8'hAA, 0, 0, 0, 3'b000);
    add(1, 8'h55, 3'b000, 3'b111, 3'b010, 8'h55, 0, 0, 0, 3'b000);
    add(1, 8'h0F, 3'b000, 3'b111, 3'b010, 8'h0F, 0, 0, 0, 3'b000);
    add(0, 8'hFD, 3'b000, 3'b111, 3'b000, 8'h00, 0, 1, 0, 3'b000);
    add(0, 8'hFD, 3'b000, 3'b111, 3'b010, 8'hFD, 0, 1, 0, 3'b000);
    add(0, 8'hFD, 3'b000, 3'b111, 3'b000, 8'h00, 0, 1, 0, 3'b000);
    add(0, 8'h00, 3'b000, 3'b111, 3'b000, 8'h00, 0, 0, 0, 3'b000);
    // Same packet with a wrong parity byte
    add(1, 8'h0D, 3'b000, 3'b111, 3'b000, 8'h00, 0, 0, 0, 3'b000);
    add(1, 8'hAA, 3'b000, 3'b111, 3'b010, 8'h0D, 1, 1, 0, 3'b000);
    add(1, 8'hAA, 3'b000, 3'b111, 3'b010, 8'hAA, 0, 0, 0, 3'b000);
    add(1, 8'h55, 3'b000, 3'b111, 3'b010, 8'h55, 0, 0, 0, 3'b000);
    add(1, 8'h0F, 3'b000, 3'b111, 3'b010, 8'h0F, 0, 0, 0, 3'b000);
    add(0, 8'h00, 3'b000, 3'b111, 3'b000, 8'h00, 0, 1, 0, 3'b000);
    add(0, 8'h00, 3'b000, 3'b111, 3'b010, 8'h00, 0, 1, 0, 3'b000);
    add(0, 8'h00, 3'b000, 3'b111, 3'b000, 8'h00, 0, 1, 0, 3'b000);
    add(0, 8'h00, 3'b000, 3'b111, 3'b000, 8'h00, 0, 0, 1, 3'b000);
    // Header with address 3 is dropped; err holds
    add(1, 8'h03, 3'b000, 3'b111, 3'b000, 8'h00, 0, 0, 1, 3'b000);
    add(1, 8'h03, 3'b000, 3'b111, 3'b000, 8'h00, 0, 0, 1, 3'b000);
    // Channel 0 packet, FIFO full during 2nd payload byte: parity 0C^11^22^33 = 0C
    add(1, 8'h0C, 3'b000, 3'b111, 3'b000, 8'h00, 0, 0, 1, 3'b000);
    add(1, 8'h11, 3'b000, 3'b111, 3'b001, 8'h0C, 1, 1, 1, 3'b000);
    add(1, 8'h11, 3'b000, 3'b111, 3'b001, 8'h11, 0, 0, 0, 3'b000);
    add(1, 8'h22, 3'b001, 3'b111, 3'b000, 8'h00, 0, 1, 0, 3'b000);
    add(1, 8'h22, 3'b001, 3'b111, 3'b000, 8'h00, 0, 1, 0, 3'b000);
    add(1, 8'h22, 3'b000, 3'b111, 3'b000, 8'h00, 0, 1, 0, 3'b000);
    add(1, 8'h22, 3'b000, 3'b111, 3'b001, 8'h22, 0, 1, 0, 3'b000);
    add(1, 8'h33, 3'b000, 3'b111, 3'b001, 8'h33, 0, 0, 0, 3'b000);
    add(0, 8'h0C, 3'b000, 3'b111, 3'b000, 8'h00, 0, 1, 0, 3'b000);
    add(0, 8'h0C, 3'b000, 3'b111, 3'b001, 8'h0C, 0, 1, 0, 3'b000);
    add(0, 8'h0C, 3'b000, 3'b111, 3'b000, 8'h00, 0, 1, 0, 3'b000);
    add(0, 8'h00, 3'b000, 3'b111, 3'b000, 8'h00, 0, 0, 0, 3'b000);
    // Channel 2 not empty at header: wait, then full during parity: parity 06^77 = 71
    add(1, 8'h06, 3'b000, 3'b011, 3'b000, 8'h00, 0, 0, 0, 3'b100);
    add(1, 8'h77, 3'b000, 3'b011, 3'b000, 8'h00, 0, 1, 0, 3'b100);
    add(1, 8'h77, 3'b000, 3'b111, 3'b000, 8'h00, 0, 1, 0, 3'b000);
    add(1, 8'h77, 3'b000, 3'b111, 3'b100, 8'h06, 1, 1, 0, 3'b000);
    add(1, 8'h77, 3'b000, 3'b111, 3'b100, 8'h77, 0, 0, 0, 3'b000);
    add(0, 8'h71, 3'b000, 3'b111, 3'b000, 8'h00, 0, 1, 0, 3'b000);
    add(0, 8'h71, 3'b100, 3'b111, 3'b000, 8'h00, 0, 1, 0, 3'b000);
    add(0, 8'h71, 3'b000, 3'b111, 3'b100, 8'h71, 0, 1, 0, 3'b000);
    add(0, 8'h71, 3'b000, 3'b111, 3'b000, 8'h00, 0, 1, 0, 3'b000);
    add(0, 8'h00, 3'b000, 3'b111, 3'b000, 8'h00, 0, 0, 0, 3'b000);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      bus.pkt_valid  = vecs[i].pv;
      bus.data_in    = vecs[i].din;
      bus.fifo_full  = vecs[i].full;
      bus.fifo_empty = vecs[i].empty;
      #2;
      ok = bus.write_enb === vecs[i].we && bus.lfd_state === vecs[i].lfd &&
           bus.busy === vecs[i].busy && bus.err === vecs[i].err &&
           bus.vld_out === vecs[i].vld && bus.soft_reset === 3'b000 &&
           (vecs[i].we == 3'b000 || bus.fifo_data === vecs[i].fd);
      check($sformatf("vec[%0d]", i), ok,
            $sformatf("got we=%b fd=%h lfd=%b busy=%b err=%b vld=%b sr=%b, want we=%b fd=%h lfd=%b busy=%b err=%b vld=%b sr=000",
                      bus.write_enb, bus.fifo_data, bus.lfd_state, bus.busy, bus.err, bus.vld_out,
                      bus.soft_reset, vecs[i].we, vecs[i].fd, vecs[i].lfd, vecs[i].busy,
                      vecs[i].err, vecs[i].vld));
    end

    // Idle watchdog on channel 2: one pulse after exactly TIMEOUT unread cycles
    bus.pkt_valid  = 1'b0;
    bus.fifo_empty = 3'b011;
    watch_pulse(C_TIMEOUT + 4, 2, f, n);
    check("timeout_first", f == C_TIMEOUT, $sformatf("got edge %0d, want %0d", f, C_TIMEOUT));
    check("timeout_count", n == 1, $sformatf("got %0d pulses, want 1", n));
    bus.fifo_empty = 3'b111;
    step();

    // Read on the expiry cycle wins: no pulse, count restarts
    bus.fifo_empty = 3'b011;
    repeat (C_TIMEOUT - 1) @(negedge clock);
    bus.read_enb = 3'b100;
    step();
    check("read_wins", bus.soft_reset === 3'b000, $sformatf("got sr=%b, want 000", bus.soft_reset));
    bus.read_enb = 3'b000;
    watch_pulse(C_TIMEOUT + 2, 2, f, n);
    check("read_restart", f == C_TIMEOUT && n == 1,
          $sformatf("got edge %0d count %0d, want edge %0d count 1", f, n, C_TIMEOUT));
    bus.fifo_empty = 3'b111;
    step();

    // Mid-packet: channel 0 flush is ignored, channel 2 flush aborts the packet
    bus.fifo_empty = 3'b110;
    bus.pkt_valid  = 1'b1;
    bus.data_in    = 8'h0A;
    step();
    bus.data_in    = 8'h40;
    bus.fifo_empty = 3'b010;
    seen0 = 1'b0;
    seen2 = 1'b0;
    for (int c = 0; c < 3 * C_TIMEOUT; c++) begin
      step();
      if (bus.soft_reset[0]) begin
        seen0 = 1'b1;
        check("nonaddr_sr", bus.write_enb === 3'b100 && bus.busy === 1'b0,
              $sformatf("got we=%b busy=%b, want we=100 busy=0", bus.write_enb, bus.busy));
      end
      if (bus.soft_reset[2]) begin
        seen2 = 1'b1;
        check("abort_cycle", bus.write_enb === 3'b000,
              $sformatf("got we=%b, want 000", bus.write_enb));
        break;
      end
      bus.data_in = bus.data_in + 8'd1;
    end
    check("pulses_seen", seen0 && seen2, $sformatf("got ch0=%b ch2=%b, want 1 1", seen0, seen2));
    bus.pkt_valid  = 1'b0;
    bus.fifo_empty = 3'b111;
    step();
    check("abort_to_decode", bus.busy === 1'b0 && bus.write_enb === 3'b000 && bus.err === 1'b0,
          $sformatf("got busy=%b we=%b err=%b, want 0 000 0", bus.busy, bus.write_enb, bus.err));

    // Short bad-parity packet leaves err set; async reset clears it at once
    bus.pkt_valid = 1'b1;
    bus.data_in   = 8'h05;
    step();
    bus.pkt_valid = 1'b0;
    bus.data_in   = 8'h00;
    repeat (4) step();
    check("err_set", bus.err === 1'b1, $sformatf("got err=%b, want 1", bus.err));
    resetn = 1'b0;
    #1;
    check("rst_err", bus.err === 1'b0, $sformatf("got err=%b, want 0", bus.err));
    @(negedge clock);
    resetn = 1'b1;

    // Async reset while stalled in LOAD_DATA
    bus.pkt_valid = 1'b1;
    bus.data_in   = 8'h0D;
    step();
    bus.data_in = 8'hAA;
    step();
    check("rst_pre", bus.write_enb === 3'b010 && bus.busy === 1'b0,
          $sformatf("got we=%b busy=%b, want 010 0", bus.write_enb, bus.busy));
    bus.pkt_valid = 1'b0;
    #1;
    check("rst_pre_stall", bus.busy === 1'b1, $sformatf("got busy=%b, want 1", bus.busy));
    resetn = 1'b0;
    #1;
    check("rst_async",
          bus.write_enb === 3'b000 && bus.busy === 1'b0 && bus.lfd_state === 1'b0 &&
          bus.err === 1'b0 && bus.soft_reset === 3'b000,
          $sformatf("got we=%b busy=%b lfd=%b err=%b sr=%b, want all zero",
                    bus.write_enb, bus.busy, bus.lfd_state, bus.err, bus.soft_reset));
    @(negedge clock);
    resetn = 1'b1;
    step();
    check("post_reset_decode", bus.busy === 1'b0 && bus.write_enb === 3'b000,
          $sformatf("got busy=%b we=%b, want 0 000", bus.busy, bus.write_enb));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/router_ctrl.md
ROUTER_CTRL -- requirements
Module: router_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 30, meaning consecutive unread cycles before a channel soft reset (range 2..31).
REQ-002 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port pkt_valid  input  1  high during header and payload bytes, low during the parity byte.
REQ-005 SHALL have port data_in  input  8  packet byte. Header: [1:0] destination 0..2, [7:2] payload length.
REQ-006 SHALL have ports fifo_full, fifo_empty, read_enb  input  3 each  per-channel FIFO status and downstream read strobes.
REQ-007 SHALL have port write_enb  output  3  one-hot FIFO write strobe.
REQ-008 SHALL have port fifo_data  output  8  byte to be written to the FIFO.
REQ-009 SHALL have ports lfd_state, busy, err  output  1 each: header-write flag, sender stall, parity error.
REQ-010 SHALL have ports vld_out, soft_reset  output  3 each: per-channel data-available flag and FIFO flush pulse.

Function
REQ-011 SHALL implement FSM states DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY and CHECK_PARITY_ERROR.
REQ-012 SHALL transition from DECODE_ADDRESS when pkt_valid=1 and data_in[1:0]<3:
  - latch addr and header;
  - go to LOAD_FIRST_DATA if fifo_empty[addr]=1, else to WAIT_TILL_EMPTY.
REQ-013 SHALL remain in DECODE_ADDRESS with no write when the address is 3, so the byte is dropped.
REQ-014 SHALL, in WAIT_TILL_EMPTY: busy=1; go to LOAD_FIRST_DATA when fifo_empty[addr]=1.
REQ-015 SHALL, in LOAD_FIRST_DATA:
  - busy=1, lfd_state=1, write_enb[addr]=1, fifo_data=latched header;
  - clear err; parity register = header;
  - next state LOAD_DATA unconditionally.
REQ-016 SHALL, in LOAD_DATA with fifo_data=data_in, act on pkt_valid and fifo_full[addr]:
  - pkt_valid=1, not full: write, parity ^= data_in, stay, busy=0;
  - pkt_valid=1, full: no write, busy=1, go to FIFO_FULL_STATE;
  - pkt_valid=0: no write, busy=1, go to LOAD_PARITY.
REQ-017 SHALL, in FIFO_FULL_STATE: busy=1, no write; go to LOAD_AFTER_FULL when fifo_full[addr]=0.
REQ-018 SHALL, in LOAD_AFTER_FULL:
  - busy=1; write held data_in; parity ^= data_in;
  - go to LOAD_DATA if pkt_valid=1, else to LOAD_PARITY.
REQ-019 SHALL, in LOAD_PARITY:
  - busy=1; if fifo_full[addr]=0, write data_in (parity byte), latch it, go to CHECK_PARITY_ERROR;
  - otherwise stay without writing.
REQ-020 SHALL, in CHECK_PARITY_ERROR: busy=1, no write; register err = (parity register != received parity); go to DECODE_ADDRESS.
REQ-021 SHALL hold err until the next LOAD_FIRST_DATA.
REQ-022 SHALL drive write_enb at most one-hot, and zero outside the write cases above.
REQ-023 SHALL drive vld_out[k] = ~fifo_empty[k] combinationally.
REQ-024 SHALL keep a 5-bit counter per channel:
  - increments while vld_out[k]=1 and read_enb[k]=0;
  - clears on read_enb[k]=1 or fifo_empty[k]=1.
REQ-025 SHALL, when counter k reaches TIMEOUT-1 and increments: pulse soft_reset[k] (registered) for exactly one cycle and clear counter k.
REQ-026 SHALL abort to DECODE_ADDRESS, with no write and err unchanged, when soft_reset[addr]=1 in any state other than DECODE_ADDRESS.
REQ-027 SHALL handle simultaneous events:
  - soft_reset on a non-addressed channel does not affect the FSM;
  - read_enb and timeout on the same cycle: the read wins, counter clears, no pulse.

Reset
REQ-028 SHALL, while resetn=0, asynchronously force:
  - state DECODE_ADDRESS; addr, header, parity and all counters to 0;
  - err=0, soft_reset=0, write_enb=0, busy=0, lfd_state=0.
REQ-029 SHALL discard any packet in progress when reset is asserted mid-packet; the first edge after release evaluates DECODE_ADDRESS.

Verification
REQ-030 SHALL pass: header 0x0D to empty FIFO 1, payload 0xAA,0x55,0x0F, parity 0x0D^0xAA^0x55^0x0F -> write_enb=3'b010 for 5 cycles, lfd_state on the first write, err=0.
REQ-031 SHALL pass: same packet with parity byte 0x00 -> err=1 one cycle after CHECK_PARITY_ERROR, cleared at the next LOAD_FIRST_DATA.
REQ-032 SHALL pass: fifo_full[0] raised during the 2nd payload byte -> busy=1, no write while full, held byte written once in LOAD_AFTER_FULL, byte count exact.
REQ-033 SHALL pass: header 0x03 with pkt_valid=1 -> stays in DECODE_ADDRESS, write_enb=0, busy=0.
REQ-034 SHALL pass: fifo_empty[2]=0, read_enb[2]=0 for TIMEOUT cycles -> a single soft_reset[2] pulse; if addr=2 mid-packet, FSM returns to DECODE_ADDRESS.
REQ-035 SHALL pass: resetn pulsed low in LOAD_DATA -> all outputs reset immediately, without a clock edge.
